// File: rtl/feeder_pkg.sv
// Shared types and helpers for the layer feeder.
//   feeder_state_t : top-level FSM state encoding
//   cnt_width()    : bits needed to address 0..n-1 (minimum 1)
package feeder_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } feeder_state_t;

  // Fill counters use cnt_width(DEPTH+1), read pointers use cnt_width(DEPTH).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/feeder_if.sv
// Host load port, accelerator read port and layer control of the feeder.
//   master : host / accelerator side (drives loads, go, strobes, end_op)
//   slave  : layer_feeder side (drives ld_ready, start_conv, ifm, wgt, busy, done)
interface feeder_if #(
  parameter int unsigned IFM_WIDTH    = 16,
  parameter int unsigned WEIGHT_WIDTH = 16
);
  localparam int unsigned LD_WIDTH = (IFM_WIDTH > WEIGHT_WIDTH) ? IFM_WIDTH : WEIGHT_WIDTH;

  logic                    ld_valid;
  logic                    ld_sel;
  logic [LD_WIDTH-1:0]     ld_data;
  logic                    ld_ready;
  logic                    go;
  logic                    start_conv;
  logic                    ifm_read;
  logic [IFM_WIDTH-1:0]    ifm;
  logic                    wgt_read;
  logic [WEIGHT_WIDTH-1:0] wgt;
  logic                    end_op;
  logic                    busy;
  logic                    done;

  modport master (
    output ld_valid, ld_sel, ld_data, go, ifm_read, wgt_read, end_op,
    input  ld_ready, start_conv, ifm, wgt, busy, done
  );

  modport slave (
    input  ld_valid, ld_sel, ld_data, go, ifm_read, wgt_read, end_op,
    output ld_ready, start_conv, ifm, wgt, busy, done
  );
endinterface

// File: rtl/feeder_ram.sv
// Single write port, registered read port with read enable.
//   clk, rst_n           : clock, async active-low reset (read register only)
//   we, waddr, wdata     : write port
//   re, raddr, rdata     : read port; rdata updates one edge after re, else holds
module feeder_ram
  import feeder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array: deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read data, reset to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/layer_feeder.sv
// Buffers one layer of ifm and weights from the host, fires start_conv, then
// serves the convolution's ifm_read / wgt_read strobes until end_op.
//   clk, rst_n : clock, async active-low reset
//   bus        : feeder_if.slave (load port, go/start_conv, read port, end_op/busy/done)
module layer_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned IFM_WIDTH    = 16,
  parameter int unsigned WEIGHT_WIDTH = 16,
  parameter int unsigned IFM_DEPTH    = 2187,
  parameter int unsigned WGT_DEPTH    = 600
) (
  input  logic     clk,
  input  logic     rst_n,
  feeder_if.slave  bus
);

  localparam int unsigned IFW = cnt_width(IFM_DEPTH + 1);
  localparam int unsigned IPW = cnt_width(IFM_DEPTH);
  localparam int unsigned WFW = cnt_width(WGT_DEPTH + 1);
  localparam int unsigned WPW = cnt_width(WGT_DEPTH);

  localparam logic [IFW-1:0] IFM_FULL = IFW'(IFM_DEPTH);
  localparam logic [WFW-1:0] WGT_FULL = WFW'(WGT_DEPTH);
  localparam logic [IPW-1:0] IFM_LAST = IPW'(IFM_DEPTH - 1);
  localparam logic [WPW-1:0] WGT_LAST = WPW'(WGT_DEPTH - 1);

  feeder_state_t  state;
  logic [IFW-1:0] ifm_cnt;
  logic [WFW-1:0] wgt_cnt;
  logic [IPW-1:0] ifm_rp;
  logic [WPW-1:0] wgt_rp;
  logic           start_conv_q, busy_q, done_q;

  logic ifm_full_c, wgt_full_c, ld_ready_c;
  logic ifm_we_c, wgt_we_c, ifm_re_c, wgt_re_c;

  // Load acceptance and read strobe qualification.
  always_comb begin
    ifm_full_c = (ifm_cnt == IFM_FULL);
    wgt_full_c = (wgt_cnt == WGT_FULL);
    ld_ready_c = (state == LOAD) && (bus.ld_sel ? !wgt_full_c : !ifm_full_c);
    ifm_we_c   = bus.ld_valid && ld_ready_c && !bus.ld_sel;
    wgt_we_c   = bus.ld_valid && ld_ready_c &&  bus.ld_sel;
    ifm_re_c   = (state == RUN) && bus.ifm_read;
    wgt_re_c   = (state == RUN) && bus.wgt_read;
  end

  // FSM, fill counters, read pointers and control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      ifm_cnt      <= '0;
      wgt_cnt      <= '0;
      ifm_rp       <= '0;
      wgt_rp       <= '0;
      start_conv_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      start_conv_q <= 1'b0;
      done_q       <= 1'b0;
      case (state)
        LOAD: begin
          if (ifm_we_c) ifm_cnt <= ifm_cnt + IFW'(1);
          if (wgt_we_c) wgt_cnt <= wgt_cnt + WFW'(1);
          if (bus.go && ifm_full_c && wgt_full_c) begin
            state        <= ARM;
            start_conv_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ARM: begin
          ifm_rp <= '0;
          wgt_rp <= '0;
          state  <= RUN;
        end
        RUN: begin
          // Pointers wrap so the map can be re-passed once per output channel.
          if (ifm_re_c) ifm_rp <= (ifm_rp == IFM_LAST) ? '0 : ifm_rp + IPW'(1);
          if (wgt_re_c) wgt_rp <= (wgt_rp == WGT_LAST) ? '0 : wgt_rp + WPW'(1);
          if (bus.end_op) begin
            state   <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ifm_cnt <= '0;
            wgt_cnt <= '0;
          end
        end
        DONE:    state <= LOAD;
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.ld_ready   = ld_ready_c;
  assign bus.start_conv = start_conv_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  feeder_ram #(.WIDTH(IFM_WIDTH), .DEPTH(IFM_DEPTH)) u_ifm_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ifm_we_c),
    .waddr (IPW'(ifm_cnt)),
    .wdata (IFM_WIDTH'(bus.ld_data)),
    .re    (ifm_re_c),
    .raddr (ifm_rp),
    .rdata (bus.ifm)
  );

  feeder_ram #(.WIDTH(WEIGHT_WIDTH), .DEPTH(WGT_DEPTH)) u_wgt_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wgt_we_c),
    .waddr (WPW'(wgt_cnt)),
    .wdata (WEIGHT_WIDTH'(bus.ld_data)),
    .re    (wgt_re_c),
    .raddr (wgt_rp),
    .rdata (bus.wgt)
  );

endmodule

// File: tb/tb_layer_feeder.sv
// Self-checking bench for layer_feeder with IFM_DEPTH=4, WGT_DEPTH=3.
// Expected read data is pushed to queues as strobes are driven and popped
// after the edge that should produce it.
module tb_layer_feeder;

  localparam int unsigned IW = 16;
  localparam int unsigned WW = 16;
  localparam int ID = 4;
  localparam int WD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  feeder_if #(.IFM_WIDTH(IW), .WEIGHT_WIDTH(WW)) bus ();

  layer_feeder #(
    .IFM_WIDTH(IW), .WEIGHT_WIDTH(WW), .IFM_DEPTH(ID), .WGT_DEPTH(WD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  logic [15:0] m_ifm [ID];
  logic [15:0] m_wgt [WD];
  int          m_irp, m_wrp, m_icnt, m_wcnt;
  logic [15:0] m_ifm_out, m_wgt_out;
  logic [15:0] exp_ifm_q [$];
  logic [15:0] exp_wgt_q [$];
  logic [15:0] e;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_irp = 0; m_wrp = 0; m_icnt = 0; m_wcnt = 0;
    m_ifm_out = '0; m_wgt_out = '0;
    exp_ifm_q.delete();
    exp_wgt_q.delete();
  endtask

  // Drive one load word through a single edge; ld_ready must be high.
  task automatic load_word(input logic sel, input logic [15:0] d);
    bus.ld_valid = 1'b1; bus.ld_sel = sel; bus.ld_data = d;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b1) $display("FAIL load_ready sel=%0d word=%0d: got %b expected 1", sel, d, bus.ld_ready);
    else passed++;
    step();
    bus.ld_valid = 1'b0;
    if (sel) begin m_wgt[m_wcnt] = d; m_wcnt++; end
    else     begin m_ifm[m_icnt] = d; m_icnt++; end
  endtask

  // Drive strobes for one edge and queue the expected registered outputs.
  task automatic drive_strobes(input logic ir, input logic wr, input logic eop, input logic in_run);
    bus.ifm_read = ir; bus.wgt_read = wr; bus.end_op = eop;
    if (in_run && ir) begin
      m_ifm_out = m_ifm[m_irp];
      m_irp = (m_irp == ID - 1) ? 0 : m_irp + 1;
    end
    if (in_run && wr) begin
      m_wgt_out = m_wgt[m_wrp];
      m_wrp = (m_wrp == WD - 1) ? 0 : m_wrp + 1;
    end
    exp_ifm_q.push_back(m_ifm_out);
    exp_wgt_q.push_back(m_wgt_out);
    step();
    bus.ifm_read = 1'b0; bus.wgt_read = 1'b0; bus.end_op = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.ld_ready !== 1'b1)  $display("FAIL rst_ld_ready: got %b expected 1", bus.ld_ready); else passed++;
    checks++; if (bus.start_conv !== 1'b0) $display("FAIL rst_start_conv: got %b expected 0", bus.start_conv); else passed++;
    checks++; if (bus.busy !== 1'b0)      $display("FAIL rst_busy: got %b expected 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0)      $display("FAIL rst_done: got %b expected 0", bus.done); else passed++;
    checks++; if (bus.ifm !== 16'd0)      $display("FAIL rst_ifm: got %0d expected 0", bus.ifm); else passed++;
    checks++; if (bus.wgt !== 16'd0)      $display("FAIL rst_wgt: got %0d expected 0", bus.wgt); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_go_blocked();
    for (int i = 0; i < 3; i++) load_word(1'b0, 16'(10 + i));
    for (int i = 0; i < 3; i++) load_word(1'b1, 16'(20 + i));
    bus.go = 1'b1;
    step();
    checks++; if (bus.start_conv !== 1'b0) $display("FAIL go_partial_start: got %b expected 0", bus.start_conv); else passed++;
    step();
    bus.go = 1'b0;
    checks++; if (bus.busy !== 1'b0) $display("FAIL go_partial_busy: got %b expected 0", bus.busy); else passed++;
    load_word(1'b0, 16'd13);
    bus.ld_valid = 1'b1; bus.ld_sel = 1'b0; bus.ld_data = 16'd99;
    #1;
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL full_ifm_ready: got %b expected 0", bus.ld_ready); else passed++;
    bus.ld_sel = 1'b1;
    #1;
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL full_wgt_ready: got %b expected 0", bus.ld_ready); else passed++;
    step();
    bus.ld_valid = 1'b0;
  endtask

  task automatic test_strobe_in_load();
    for (int i = 0; i < 2; i++) begin
      drive_strobes(1'b1, 1'b1, 1'b0, 1'b0);
      e = exp_ifm_q.pop_front();
      checks++; if (bus.ifm !== e) $display("FAIL load_strobe_ifm: got %0d expected %0d", bus.ifm, e); else passed++;
      e = exp_wgt_q.pop_front();
      checks++; if (bus.wgt !== e) $display("FAIL load_strobe_wgt: got %0d expected %0d", bus.wgt, e); else passed++;
    end
  endtask

  task automatic test_start();
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    checks++; if (bus.start_conv !== 1'b1) $display("FAIL start_pulse: got %b expected 1", bus.start_conv); else passed++;
    checks++; if (bus.busy !== 1'b1)       $display("FAIL start_busy_arm: got %b expected 1", bus.busy); else passed++;
    step();
    checks++; if (bus.start_conv !== 1'b0) $display("FAIL start_pulse_end: got %b expected 0", bus.start_conv); else passed++;
    checks++; if (bus.busy !== 1'b1)       $display("FAIL start_busy_run: got %b expected 1", bus.busy); else passed++;
    m_irp = 0; m_wrp = 0;
  endtask

  task automatic test_ifm_stream();
    for (int i = 0; i < 5; i++) begin
      drive_strobes(1'b1, 1'b0, 1'b0, 1'b1);
      e = exp_ifm_q.pop_front();
      checks++; if (bus.ifm !== e) $display("FAIL stream_ifm[%0d]: got %0d expected %0d", i, bus.ifm, e); else passed++;
      e = exp_wgt_q.pop_front();
      checks++; if (bus.wgt !== e) $display("FAIL stream_wgt_hold[%0d]: got %0d expected %0d", i, bus.wgt, e); else passed++;
    end
  endtask

  task automatic test_end_op();
    bus.ld_sel = 1'b0;
    drive_strobes(1'b1, 1'b0, 1'b1, 1'b1);
    e = exp_ifm_q.pop_front();
    checks++; if (bus.ifm !== e)        $display("FAIL endop_ifm: got %0d expected %0d", bus.ifm, e); else passed++;
    void'(exp_wgt_q.pop_front());
    checks++; if (bus.done !== 1'b1)    $display("FAIL endop_done: got %b expected 1", bus.done); else passed++;
    checks++; if (bus.busy !== 1'b0)    $display("FAIL endop_busy: got %b expected 0", bus.busy); else passed++;
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL done_ld_ready: got %b expected 0", bus.ld_ready); else passed++;
    // Strobes during DONE are ignored.
    drive_strobes(1'b1, 1'b1, 1'b0, 1'b0);
    e = exp_ifm_q.pop_front();
    checks++; if (bus.ifm !== e)        $display("FAIL done_strobe_ifm: got %0d expected %0d", bus.ifm, e); else passed++;
    e = exp_wgt_q.pop_front();
    checks++; if (bus.wgt !== e)        $display("FAIL done_strobe_wgt: got %0d expected %0d", bus.wgt, e); else passed++;
    checks++; if (bus.done !== 1'b0)    $display("FAIL done_pulse_end: got %b expected 0", bus.done); else passed++;
    checks++; if (bus.ld_ready !== 1'b1) $display("FAIL reload_ld_ready: got %b expected 1", bus.ld_ready); else passed++;
    m_icnt = 0; m_wcnt = 0;
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    checks++; if (bus.start_conv !== 1'b0) $display("FAIL go_empty_start: got %b expected 0", bus.start_conv); else passed++;
    checks++; if (bus.busy !== 1'b0)       $display("FAIL go_empty_busy: got %b expected 0", bus.busy); else passed++;
  endtask

  task automatic test_dual_read();
    for (int i = 0; i < 4; i++) load_word(1'b0, 16'(30 + i));
    for (int i = 0; i < 3; i++) load_word(1'b1, 16'(40 + i));
    test_start();
    for (int i = 0; i < 4; i++) begin
      drive_strobes(1'b1, 1'b1, 1'b0, 1'b1);
      e = exp_ifm_q.pop_front();
      checks++; if (bus.ifm !== e) $display("FAIL dual_ifm[%0d]: got %0d expected %0d", i, bus.ifm, e); else passed++;
      e = exp_wgt_q.pop_front();
      checks++; if (bus.wgt !== e) $display("FAIL dual_wgt[%0d]: got %0d expected %0d", i, bus.wgt, e); else passed++;
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 2; i++) begin
      drive_strobes(1'b1, 1'b0, 1'b0, 1'b1);
      e = exp_ifm_q.pop_front();
      checks++; if (bus.ifm !== e) $display("FAIL prerst_ifm[%0d]: got %0d expected %0d", i, bus.ifm, e); else passed++;
      void'(exp_wgt_q.pop_front());
    end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0)     $display("FAIL midrst_busy: got %b expected 0", bus.busy); else passed++;
    checks++; if (bus.ifm !== 16'd0)     $display("FAIL midrst_ifm: got %0d expected 0", bus.ifm); else passed++;
    checks++; if (bus.wgt !== 16'd0)     $display("FAIL midrst_wgt: got %0d expected 0", bus.wgt); else passed++;
    checks++; if (bus.ld_ready !== 1'b1) $display("FAIL midrst_ld_ready: got %b expected 1", bus.ld_ready); else passed++;
    model_reset();
    bus.end_op = 1'b1;
    step();
    checks++; if (bus.done !== 1'b0)     $display("FAIL midrst_done: got %b expected 0", bus.done); else passed++;
    bus.end_op = 1'b0;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) load_word(1'b0, 16'(50 + i));
    for (int i = 0; i < 3; i++) load_word(1'b1, 16'(60 + i));
    test_start();
    drive_strobes(1'b1, 1'b1, 1'b0, 1'b1);
    e = exp_ifm_q.pop_front();
    checks++; if (bus.ifm !== e) $display("FAIL reload_ifm0: got %0d expected %0d", bus.ifm, e); else passed++;
    e = exp_wgt_q.pop_front();
    checks++; if (bus.wgt !== e) $display("FAIL reload_wgt0: got %0d expected %0d", bus.wgt, e); else passed++;
    drive_strobes(1'b0, 1'b0, 1'b1, 1'b1);
    void'(exp_ifm_q.pop_front());
    void'(exp_wgt_q.pop_front());
    checks++; if (bus.done !== 1'b1) $display("FAIL final_done: got %b expected 1", bus.done); else passed++;
  endtask

  initial begin
    bus.ld_valid = 1'b0; bus.ld_sel = 1'b0; bus.ld_data = '0; bus.go = 1'b0;
    bus.ifm_read = 1'b0; bus.wgt_read = 1'b0; bus.end_op = 1'b0;
    test_reset();
    test_go_blocked();
    test_strobe_in_load();
    test_start();
    test_ifm_stream();
    test_end_op();
    test_dual_read();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/layer_feeder.md
# layer_feeder

Input-side transmitter for the CONV/POOL accelerator chain. Buffers one layer's input feature map and weight set, loaded word-by-word from a host port. Issues the `start_conv` pulse, then answers the accelerator's `ifm_read`/`wgt_read` strobes with registered data, using the same one-cycle read semantics as the inter-stage RAM. It sits in front of the first convolution and runs until the chain reports `end_op`.

## Interface
Parameters:
- `IFM_WIDTH`, 16, width of the ifm word.
- `WEIGHT_WIDTH`, 16, width of the weight word.
- `IFM_DEPTH`, 2187, ifm words per layer (CI*IFM_SIZE*IFM_SIZE = 3*27*27).
- `WGT_DEPTH`, 600, weight words per layer (CO*CI*K*K = 8*3*5*5).

Ports:
- `clk`, in, 1, single clock for the whole block.
- `rst_n`, in, 1, asynchronous, active-low reset.
- `ld_valid`, in, 1, host load word valid.
- `ld_sel`, in, 1, load target: 0 = ifm buffer, 1 = weight buffer.
- `ld_data`, in, max(IFM_WIDTH,WEIGHT_WIDTH), load word; LSBs are used for the narrower target.
- `ld_ready`, out, 1, the selected buffer accepts the word this cycle.
- `go`, in, 1, request to start the layer.
- `start_conv`, out, 1, one-cycle start pulse to the convolution.
- `ifm_read`, in, 1, read strobe from the convolution for the next ifm word.
- `ifm`, out, IFM_WIDTH, registered ifm word.
- `wgt_read`, in, 1, read strobe from the convolution for the next weight word.
- `wgt`, out, WEIGHT_WIDTH, registered weight word.
- `end_op`, in, 1, end-of-layer flag from the last pooling stage.
- `busy`, out, 1, high in ARM and RUN.
- `done`, out, 1, one-cycle pulse when the layer completes.

## Operation
- States: LOAD, ARM, RUN, DONE. Reset state is LOAD.
- LOAD
  - `ld_ready = (ld_sel ? wgt_cnt < WGT_DEPTH : ifm_cnt < IFM_DEPTH)`.
  - A transfer occurs on `ld_valid && ld_ready`. It writes `mem[cnt]` and increments that counter.
  - Words offered to a full buffer are not accepted; the host must hold them or drop them.
  - When `go=1` and both counters are full, the next state is ARM. `go` is ignored while either buffer is not full.
- ARM: `start_conv=1` for exactly one cycle; read pointers are cleared to 0; next state is RUN.
- RUN
  - An `ifm_read` in cycle t loads `ifm <= ifm_mem[ifm_rp]` at edge t+1, and `ifm_rp` increments.
  - `ifm_rp` wraps from IFM_DEPTH-1 to 0. This lets the convolution re-pass the map once per output channel. `wgt`/`wgt_rp` behave identically against WGT_DEPTH.
  - Both strobes may be high in the same cycle; they are independent.
  - `end_op=1` moves the state to DONE. A strobe in the same cycle as `end_op` is still served.
- DONE: `done=1` for one cycle. Both fill counters clear (the next layer needs a full reload). Next state is LOAD.
- Outside RUN, strobes are ignored and `ifm`/`wgt` hold their value.
- `ld_valid` outside LOAD is ignored and `ld_ready=0`.
- Memory contents are not reset. Counters, pointers, state and all outputs are reset.

## Timing
- Reset values:
  - `ld_ready` follows the LOAD equation with empty buffers, i.e. 1.
  - `start_conv=0`, `busy=0`, `done=0`, `ifm=0`, `wgt=0`.
- `go` to `start_conv`: 1 cycle (edge after `go` enters ARM).
- `start_conv` to first strobe served: strobes are valid from the cycle after the pulse.
- Read latency is exactly 1 cycle, with back-to-back strobes sustained at 1 word/cycle.
- `end_op` to `done`: 1 cycle. `done` to `ld_ready` high again: 1 cycle.
- Reset asserted mid-RUN: everything returns to LOAD with empty counters immediately (asynchronous), and no `done` is produced.
- Counter widths are `$clog2(DEPTH+1)` for fill counters and `$clog2(DEPTH)` for read pointers. Wrap compares against DEPTH-1 and does not rely on power-of-two overflow.

## Structure
- Shared package `feeder_pkg`:
  - State enum (LOAD, ARM, RUN, DONE).
  - A function computing counter widths from a depth.
- Sub-module `feeder_ram #(WIDTH, DEPTH)`: one write port and one registered read port with a read enable. It is instantiated twice, for ifm and for weights.
- The top level holds the FSM, the fill counters and the read pointers.

## Test plan
All scenarios use IFM_DEPTH=4 and WGT_DEPTH=3.
- Load ifm 10,11,12,13 and weights 20,21,22; pulse `go`. Expect `start_conv` for one cycle, then `ifm_read` on 5 consecutive cycles returns 10,11,12,13,10 (wrap), each 1 cycle after its strobe.
- Simultaneous `ifm_read` and `wgt_read` for 4 cycles. Expect `ifm` 10,11,12,13 and `wgt` 20,21,22,20.
- Pulse `go` after only 3 ifm words are loaded. Expect no `start_conv` and the state to stay LOAD. Expect `ld_valid` with ld_sel=0 after 4 words to see `ld_ready=0`.
- `end_op` together with `ifm_read` in RUN. Expect the word to be served, `done` one cycle later, then `ld_ready=1`, and `go` ignored until both buffers are reloaded.
- Deassert `rst_n` mid-RUN after 2 reads. Expect `busy=0`, `ifm=0` and `wgt=0` immediately, no `done`, and a reload starting again at address 0.
- Strobes in LOAD and DONE. Expect `ifm`/`wgt` unchanged and pointers unchanged; the first RUN read returns address 0.
